// File: rtl/regfile_sb_if.sv
// Bus between issue/writeback (master) and the scoreboarded register file (slave).
// Parameters must match the ones given to the attached regfile_sb.
interface regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int AW    = $clog2(NREGS)
);
    logic [NREAD*AW-1:0]   rd_sel;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic                  wr_en;
    logic [AW-1:0]         wr_sel;
    logic [XLEN-1:0]       wr_data;
    logic                  rsv_en;
    logic [AW-1:0]         rsv_sel;
    logic                  rsv_ok;
    logic                  flush;
    logic [AW:0]           busy_count;

    modport master (
        output rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel, flush,
        input  rd_data, rd_busy, rsv_ok, busy_count
    );

    modport slave (
        input  rd_sel, wr_en, wr_sel, wr_data, rsv_en, rsv_sel, flush,
        output rd_data, rd_busy, rsv_ok, busy_count
    );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with hardwired x0, write-to-read bypass and a
// per-register busy scoreboard used by issue (reserve) and writeback (release).
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NREAD = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic        clk,
    input  logic        nrst,
    regfile_sb_if.slave bus
);
    logic [XLEN-1:0]  regs [1:NREGS-1];
    logic [NREGS-1:1] busy;
    logic [NREGS-1:0] busy_full;
    logic [NREGS-1:0] busy_nxt;
    logic [AW:0]      count_nxt;
    logic [AW:0]      count_q;

    // x0 has no storage; bit 0 of the widened view is the "never busy" x0 entry.
    assign busy_full = {busy, 1'b0};

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0] sel;
        logic          byp;
        assign sel = bus.rd_sel[i*AW +: AW];
        assign byp = bus.wr_en && (bus.wr_sel == sel) && (sel != '0);
        assign bus.rd_data[i*XLEN +: XLEN] = (sel == '0) ? '0 :
                                             byp         ? bus.wr_data : regs[sel];
        assign bus.rd_busy[i] = busy_full[sel] && !byp;
    end

    assign bus.rsv_ok = bus.rsv_en && !bus.flush &&
                        ((bus.rsv_sel == '0) || !busy_full[bus.rsv_sel] ||
                         (bus.wr_en && (bus.wr_sel == bus.rsv_sel)));

    // Assignment order encodes per-register priority: flush > reserve > write-clear.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would infer a latch.
        busy_nxt  = busy_full;
        count_nxt = '0;
        if (bus.wr_en)
            busy_nxt[bus.wr_sel] = 1'b0;
        if (bus.rsv_ok)
            busy_nxt[bus.rsv_sel] = 1'b1;
        if (bus.flush)
            busy_nxt = '0;
        busy_nxt[0] = 1'b0;
        // NOTE: blocking assignments here are intended - the sum accumulates
        // within one evaluation; state registers below use non-blocking only.
        for (int r = 0; r < NREGS; r++)
            count_nxt = count_nxt + {{AW{1'b0}}, busy_nxt[r]};
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            // NOTE: the array is reset on purpose - a register never written
            // since reset must read as zero, so this is not a plain RAM.
            for (int r = 1; r < NREGS; r++)
                regs[r] <= '0;
            busy    <= '0;
            count_q <= '0;
        end else begin
            if (bus.wr_en && (bus.wr_sel != '0))
                regs[bus.wr_sel] <= bus.wr_data;
            busy    <= busy_nxt[NREGS-1:1];
            count_q <= count_nxt;
        end
    end

    assign bus.busy_count = count_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Randomised self-checking bench: default 32x32x2 instance plus a 64-bit,
// 16-register, 3-port instance, both checked against array-based models.
module tb_regfile_sb;
    logic clk;
    logic nrst;
    int   n_vec;
    int   n_err;

    regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) a ();
    regfile_sb_if #(.XLEN(64), .NREGS(16), .NREAD(3)) b ();

    regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2)) dut_a (.clk(clk), .nrst(nrst), .bus(a));
    regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(3)) dut_b (.clk(clk), .nrst(nrst), .bus(b));

    always #5 clk = ~clk;

    // Reference models: plain arrays updated by the architectural rules.
    logic [31:0] ma_regs [32];
    bit          ma_busy [32];
    logic [63:0] mb_regs [16];
    bit          mb_busy [16];

    // Last observed outputs, for directed constant checks.
    logic [31:0] oa_d [2];
    logic        oa_b [2];
    logic        oa_ok;
    logic [5:0]  oa_cnt;
    logic [63:0] ob_d [3];
    logic        ob_b [3];
    logic        ob_ok;
    logic [4:0]  ob_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin ma_regs[r] = '0; ma_busy[r] = 0; end
        for (int r = 0; r < 16; r++) begin mb_regs[r] = '0; mb_busy[r] = 0; end
    endtask

    task automatic idle_all();
        a.rd_sel = '0; a.wr_en = 0; a.wr_sel = '0; a.wr_data = '0;
        a.rsv_en = 0; a.rsv_sel = '0; a.flush = 0;
        b.rd_sel = '0; b.wr_en = 0; b.wr_sel = '0; b.wr_data = '0;
        b.rsv_en = 0; b.rsv_sel = '0; b.flush = 0;
    endtask

    // One clock of instance A: drive at edge+1, check combinational outputs, update model.
    task automatic cyc_a(input logic [4:0] s0, input logic [4:0] s1, input logic we,
                         input logic [4:0] ws, input logic [31:0] wd, input logic re,
                         input logic [4:0] rs, input logic fl);
        logic [4:0] s [2];
        logic       exp_ok;
        int         cnt;
        s[0] = s0; s[1] = s1;
        a.rd_sel = {s1, s0}; a.wr_en = we; a.wr_sel = ws; a.wr_data = wd;
        a.rsv_en = re; a.rsv_sel = rs; a.flush = fl;
        #1;
        for (int p = 0; p < 2; p++) begin
            logic [31:0] ed;
            logic        eb;
            if (s[p] == 0) begin ed = '0; eb = 0; end
            else if (we && ws == s[p]) begin ed = wd; eb = 0; end
            else begin ed = ma_regs[s[p]]; eb = ma_busy[s[p]]; end
            oa_d[p] = a.rd_data[p*32 +: 32];
            oa_b[p] = a.rd_busy[p];
            check("a_rd_data", oa_d[p], ed);
            check("a_rd_busy", oa_b[p], eb);
        end
        exp_ok = re && !fl && (rs == 0 || !ma_busy[rs] || (we && ws == rs));
        cnt = 0;
        for (int r = 1; r < 32; r++) cnt += ma_busy[r];
        oa_ok = a.rsv_ok; oa_cnt = a.busy_count;
        check("a_rsv_ok", oa_ok, exp_ok);
        check("a_busy_count", oa_cnt, cnt);
        @(posedge clk);
        if (we && ws != 0) begin ma_regs[ws] = wd; ma_busy[ws] = 0; end
        if (exp_ok && rs != 0) ma_busy[rs] = 1;
        if (fl) for (int r = 0; r < 32; r++) ma_busy[r] = 0;
        #1;
    endtask

    task automatic cyc_b(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                         input logic we, input logic [3:0] ws, input logic [63:0] wd,
                         input logic re, input logic [3:0] rs, input logic fl);
        logic [3:0] s [3];
        logic       exp_ok;
        int         cnt;
        s[0] = s0; s[1] = s1; s[2] = s2;
        b.rd_sel = {s2, s1, s0}; b.wr_en = we; b.wr_sel = ws; b.wr_data = wd;
        b.rsv_en = re; b.rsv_sel = rs; b.flush = fl;
        #1;
        for (int p = 0; p < 3; p++) begin
            logic [63:0] ed;
            logic        eb;
            if (s[p] == 0) begin ed = '0; eb = 0; end
            else if (we && ws == s[p]) begin ed = wd; eb = 0; end
            else begin ed = mb_regs[s[p]]; eb = mb_busy[s[p]]; end
            ob_d[p] = b.rd_data[p*64 +: 64];
            ob_b[p] = b.rd_busy[p];
            check("b_rd_data", ob_d[p], ed);
            check("b_rd_busy", ob_b[p], eb);
        end
        exp_ok = re && !fl && (rs == 0 || !mb_busy[rs] || (we && ws == rs));
        cnt = 0;
        for (int r = 1; r < 16; r++) cnt += mb_busy[r];
        ob_ok = b.rsv_ok; ob_cnt = b.busy_count;
        check("b_rsv_ok", ob_ok, exp_ok);
        check("b_busy_count", ob_cnt, cnt);
        @(posedge clk);
        if (we && ws != 0) begin mb_regs[ws] = wd; mb_busy[ws] = 0; end
        if (exp_ok && rs != 0) mb_busy[rs] = 1;
        if (fl) for (int r = 0; r < 16; r++) mb_busy[r] = 0;
        #1;
    endtask

    // Biased towards low registers so hazards and bypasses occur often.
    function automatic logic [4:0] rsel_a();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    function automatic logic [3:0] rsel_b();
        return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
    endfunction

    initial begin
        n_vec = 0; n_err = 0;
        clk = 0; nrst = 0;
        idle_all();
        model_reset();
        a.rd_sel = {5'd6, 5'd5};
        #3;
        check("rst_rd_data", a.rd_data[31:0], 32'h0);
        check("rst_busy_count", a.busy_count, 6'd0);
        check("rst_b_busy_count", b.busy_count, 5'd0);
        #5 nrst = 1;
        @(posedge clk); #1;

        // Asynchronous reset between edges clears data and busy immediately.
        cyc_a(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        cyc_a(0, 0, 0, 0, 0, 1, 5'd6, 0);
        idle_all();
        a.rd_sel = {5'd6, 5'd5};
        #1;
        check("pre_rst_x5", a.rd_data[31:0], 32'hDEADBEEF);
        check("pre_rst_x6_busy", a.rd_busy[1], 1'b1);
        nrst = 0;
        #1;
        check("async_rst_x5", a.rd_data[31:0], 32'h0);
        check("async_rst_x6_busy", a.rd_busy[1], 1'b0);
        check("async_rst_count", a.busy_count, 6'd0);
        model_reset();
        #1 nrst = 1;
        @(posedge clk); #1;

        // Zero register.
        cyc_a(0, 0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 0);
        check("x0_rsv_ok", oa_ok, 1'b1);
        cyc_a(0, 0, 0, 0, 0, 0, 0, 0);
        check("x0_read", oa_d[0], 32'h0);
        check("x0_busy", oa_b[0], 1'b0);
        check("x0_count", oa_cnt, 6'd0);

        // Bypass on both ports, then array readback.
        cyc_a(0, 0, 1, 5'd7, 32'h11, 0, 0, 0);
        cyc_a(5'd7, 5'd7, 1, 5'd7, 32'h22, 0, 0, 0);
        check("byp_p0", oa_d[0], 32'h22);
        check("byp_p1", oa_d[1], 32'h22);
        cyc_a(5'd7, 0, 0, 0, 0, 0, 0, 0);
        check("byp_array", oa_d[0], 32'h22);

        // Hazard on x3.
        cyc_a(0, 0, 0, 0, 0, 1, 5'd3, 0);
        check("hz_rsv1", oa_ok, 1'b1);
        cyc_a(5'd3, 0, 0, 0, 0, 1, 5'd3, 0);
        check("hz_rsv2", oa_ok, 1'b0);
        check("hz_busy", oa_b[0], 1'b1);
        check("hz_count", oa_cnt, 6'd1);
        cyc_a(0, 0, 1, 5'd3, 32'h5A, 1, 5'd3, 0);
        check("hz_wr_rsv_ok", oa_ok, 1'b1);
        cyc_a(5'd3, 0, 0, 0, 0, 0, 0, 0);
        check("hz_still_busy", oa_b[0], 1'b1);
        check("hz_data", oa_d[0], 32'h5A);

        // Flush with concurrent write and reserve.
        cyc_a(0, 0, 0, 0, 0, 0, 0, 1);
        cyc_a(0, 0, 0, 0, 0, 1, 5'd1, 0);
        cyc_a(0, 0, 0, 0, 0, 1, 5'd2, 0);
        cyc_a(0, 0, 0, 0, 0, 1, 5'd9, 0);
        cyc_a(0, 0, 1, 5'd2, 32'h77, 1, 5'd4, 1);
        check("fl_count_before", oa_cnt, 6'd3);
        check("fl_rsv_ok", oa_ok, 1'b0);
        cyc_a(5'd2, 5'd4, 0, 0, 0, 0, 0, 0);
        check("fl_count_after", oa_cnt, 6'd0);
        check("fl_x2", oa_d[0], 32'h77);
        check("fl_x4_busy", oa_b[1], 1'b0);

        for (int n = 0; n < 400; n++)
            cyc_a(rsel_a(), rsel_a(), 1'($urandom_range(0, 1)), rsel_a(), $urandom(),
                  1'($urandom_range(0, 1)), rsel_a(), ($urandom_range(0, 15) == 0));
        idle_all();

        // Wide instance: fill the scoreboard without wrap, then independent reads.
        for (int r = 1; r < 16; r++)
            cyc_b(rsel_b(), rsel_b(), rsel_b(), 0, 0, 0, 1, 4'(r), 0);
        cyc_b(0, 0, 0, 0, 0, 0, 1, 4'd5, 0);
        check("b_full_count", ob_cnt, 5'd15);
        check("b_full_rsv_ok", ob_ok, 1'b0);
        cyc_b(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int r = 1; r < 16; r++)
            cyc_b(0, 0, 0, 1, 4'(r), {$urandom(), $urandom()}, 0, 0, 0);
        cyc_b(4'd3, 4'd9, 4'd15, 0, 0, 0, 0, 0, 0);
        check("b_flushed_count", ob_cnt, 5'd0);
        for (int n = 0; n < 300; n++)
            cyc_b(rsel_b(), rsel_b(), rsel_b(), 1'($urandom_range(0, 1)), rsel_b(),
                  {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), rsel_b(),
                  ($urandom_range(0, 15) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with an integrated scoreboard, the successor to the fixed 32×32 two-read/one-write register file. It keeps the hardwired zero register and gains configurable width, depth and read-port count, same-cycle write-to-read bypass, and per-register busy tracking. Issue logic uses the busy tracking to reserve destinations and detect hazards, and writeback uses it to release them. It sits between decode/issue and writeback in the pipelined core.

## Interface

Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, architectural register count including x0; power of two, ≥4
- NREAD, 2, number of read ports
- AW, $clog2(NREGS), derived select width; not overridden

Ports:
- clk  in  1  core clock; all state updates on rising edge
- nrst  in  1  reset, asynchronous, active-low
- rd_sel  in  NREAD*AW  read selects; port i at [i*AW +: AW]
- rd_data  out  NREAD*XLEN  read data per port
- rd_busy  out  NREAD  1 = selected register has a pending write
- wr_en  in  1  writeback strobe
- wr_sel  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- rsv_en  in  1  reserve request from issue
- rsv_sel  in  AW  register to reserve
- rsv_ok  out  1  reservation accepted this cycle
- flush  in  1  clear all busy bits; data unaffected
- busy_count  out  AW+1  number of busy registers, registered

Reset and clock are fixed: one clock `clk`, with `nrst` asynchronous and active-low.

## Operation

- **State:** `regs[1..NREGS-1]` (XLEN each) and `busy[1..NREGS-1]`. x0 has no storage.
- **Reset (nrst=0):** all regs = 0, all busy = 0, busy_count = 0, applied immediately regardless of clk.
- **x0:**
  - Reads return 0 with rd_busy = 0.
  - Writes to x0 are discarded.
  - rsv_en with rsv_sel = 0 gives rsv_ok = 1 (if flush = 0) and no state change.
- **Read port i (combinational):**
  - If wr_en && wr_sel == rd_sel_i && rd_sel_i != 0, then rd_data_i = wr_data and rd_busy_i = 0 (bypass).
  - Otherwise rd_data_i = regs[rd_sel_i] and rd_busy_i = busy[rd_sel_i].
  - Bypass ignores reservations made in the same cycle.
- **Write:** on rising edge with wr_en && wr_sel != 0: regs[wr_sel] ← wr_data and busy[wr_sel] ← 0. Writing a non-busy register is legal and just updates the data.
- **Reserve (combinational):**
  - rsv_ok = rsv_en && !flush && (rsv_sel == 0 || !busy[rsv_sel] || (wr_en && wr_sel == rsv_sel)).
  - On the edge, if rsv_ok && rsv_sel != 0: busy[rsv_sel] ← 1.
- **Priority per register in one edge:** flush > reserve-set > write-clear.
  - Write and reserve to the same register: data written, busy ends 1.
  - Flush with a write: data written, busy ends 0.
- **busy_count:** registered popcount of the next-state busy vector. It therefore equals the popcount of busy after every edge. Maximum value is NREGS-1; it never wraps.

## Timing

- Read latency is 0 cycles (combinational from rd_sel, wr_*, and state).
- A write is visible through the array on the cycle after the edge, and through the bypass on the same cycle.
- rsv_ok is combinational in the same cycle as rsv_en. Issue must treat rsv_ok = 0 as a stall and hold the request.
- busy and busy_count update one edge after the reserve/write/flush.
- Asynchronous reset mid-operation aborts any in-flight write. No edge-captured state survives reset.
- No combinational path from rd_sel to rsv_ok, or from rsv_* to rd_*.

## Test plan

- **Reset:** write x5=0xDEADBEEF, reserve x6, assert nrst=0 between edges → rd_data(x5) = 0, rd_busy(x6) = 0, busy_count = 0 immediately.
- **Zero register:** wr x0=0xFFFFFFFF; reserve x0 → read x0 = 0, rd_busy = 0, rsv_ok = 1, busy_count stays 0.
- **Bypass:** x7=0x11; same cycle wr x7=0x22 while port0 and port1 read x7 → both return 0x22 with busy 0; next cycle the array returns 0x22.
- **Hazard:**
  - reserve x3 → rsv_ok = 1; next cycle rd_busy(x3) = 1 and busy_count = 1.
  - reserve x3 again → rsv_ok = 0.
  - wr x3=0x5A together with reserve x3 → rsv_ok = 1, busy remains 1, data 0x5A.
- **Flush:** reserve x1, x2, x9 over 3 cycles (busy_count = 3); flush with wr x2=0x77 and rsv x4 → rsv_ok = 0, next cycle busy_count = 0, x2 = 0x77, x4 not busy.
- **Parameter sweep:** XLEN=64, NREGS=16, NREAD=3; reserve x1..x15 → busy_count = 15 with no wrap; each port reads an independent register correctly.
